cam_sched: RTL and testbench

CAM_SCHED -- requirements
Module: cam_sched

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_prio_enc.sv | 30 +++
 rtl/cam_sched.sv | 150 +++++++++++++++
 tb/tb_cam_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants, FSM state type and result-kind encoding for cam_sched
//
// Purpose: single source of truth for the CAM geometry and scheduler types.
// Ports:   none (package).
package cam_pkg;

  localparam int ENTRIES = 16;
  localparam int DATA_W  = 7;
  localparam int IDX_W   = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    EVAL,
    WRITE,
    RESP
  } state_e;

  localparam logic RES_KIND_LKP = 1'b0;
  localparam logic RES_KIND_INS = 1'b1;

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - combinational lowest-set-bit priority encoder for the CAM match vector
//
// Purpose: turn an N-bit match vector into the index of its lowest set bit.
// Ports:   vec_i  - match vector (N bits)
//          idx_o  - index of the lowest set bit, 0 when vec_i is all zero
//          any_o  - high when at least one bit of vec_i is set
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int N = ENTRIES,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan from the top down so the last assignment wins with the lowest set bit.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_sched.sv
// rtl/cam_sched.sv - round-robin insert/lookup scheduler driving an external CAM
//
// Purpose: arbitrates insert and lookup requesters, probes the external CAM,
//          writes missing words on insert, tracks occupancy and reports one
//          result strobe per request. The CAM contents live outside this block.
// Ports:   clk, rst_n                      - clock, async active-low reset
//          ins_valid/ins_ready/ins_data    - insert request handshake and word
//          lkp_valid/lkp_ready/lkp_data    - lookup request handshake and word
//          res_valid/res_kind/res_hit/res_index/res_evict - result strobe and fields
//          cam_we/cam_content              - CAM write enable and search/write word
//          cam_match                       - CAM match vector (one cycle after content)
//          fill                            - occupied entry count, 0..ENTRIES
module cam_sched #(
  parameter int ENTRIES = cam_pkg::ENTRIES,
  parameter int DATA_W  = cam_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ins_valid,
  output logic                        ins_ready,
  input  logic [DATA_W-1:0]           ins_data,
  input  logic                        lkp_valid,
  output logic                        lkp_ready,
  input  logic [DATA_W-1:0]           lkp_data,
  output logic                        res_valid,
  output logic                        res_kind,
  output logic                        res_hit,
  output logic [$clog2(ENTRIES)-1:0]  res_index,
  output logic                        res_evict,
  output logic                        cam_we,
  output logic [DATA_W-1:0]           cam_content,
  input  logic [ENTRIES-1:0]          cam_match,
  output logic [$clog2(ENTRIES):0]    fill
);
  import cam_pkg::*;

  localparam int IW = $clog2(ENTRIES);
  localparam logic [IW:0] FULL = (IW + 1)'(ENTRIES);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              kind_q, kind_d;
  logic              hit_q, hit_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              evict_q, evict_d;
  logic              prefer_lkp_q, prefer_lkp_d;
  logic [IW:0]       fill_q, fill_d;

  logic              grant_lkp, grant_ins;
  logic [IW-1:0]     enc_idx;
  logic              enc_any;

  cam_prio_enc #(
    .N (ENTRIES),
    .W (IW)
  ) u_prio_enc (
    .vec_i (cam_match),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // The state register already reads IDLE while reset is held, so the grant is
  // also qualified by rst_n to keep both ready outputs low during reset.
  always_comb begin
    grant_lkp = 1'b0;
    grant_ins = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (lkp_valid && (!ins_valid || prefer_lkp_q)) begin
        grant_lkp = 1'b1;
      end else if (ins_valid) begin
        grant_ins = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    kind_d       = kind_q;
    hit_d        = hit_q;
    idx_d        = idx_q;
    evict_d      = evict_q;
    prefer_lkp_d = prefer_lkp_q;
    fill_d       = fill_q;
    case (state_q)
      IDLE: begin
        if (grant_lkp || grant_ins) begin
          state_d      = PROBE;
          kind_d       = grant_ins ? RES_KIND_INS : RES_KIND_LKP;
          word_d       = grant_ins ? ins_data : lkp_data;
          // Whoever was just served loses priority on the next tie.
          prefer_lkp_d = grant_ins;
        end
      end
      PROBE: state_d = EVAL;
      EVAL: begin
        hit_d   = enc_any;
        idx_d   = enc_idx;
        evict_d = 1'b0;
        if (kind_q == RES_KIND_INS && !enc_any) begin
          state_d = WRITE;
          evict_d = (fill_q == FULL);
        end else begin
          state_d = RESP;
        end
      end
      WRITE: begin
        state_d = RESP;
        // A full CAM overwrites an entry, so occupancy stays saturated.
        if (!evict_q) fill_d = fill_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      kind_q       <= RES_KIND_LKP;
      hit_q        <= 1'b0;
      idx_q        <= '0;
      evict_q      <= 1'b0;
      prefer_lkp_q <= 1'b1;
      fill_q       <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      kind_q       <= kind_d;
      hit_q        <= hit_d;
      idx_q        <= idx_d;
      evict_q      <= evict_d;
      prefer_lkp_q <= prefer_lkp_d;
      fill_q       <= fill_d;
    end
  end

  assign ins_ready   = grant_ins;
  assign lkp_ready   = grant_lkp;
  assign res_valid   = (state_q == RESP);
  assign res_kind    = res_valid & kind_q;
  assign res_hit     = res_valid & hit_q;
  assign res_index   = res_valid ? idx_q : '0;
  assign res_evict   = res_valid & evict_q;
  assign cam_we      = (state_q == WRITE);
  assign cam_content = word_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_cam_sched.sv
// tb/tb_cam_sched.sv - self-checking bench for cam_sched
module tb_cam_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_valid, ins_ready, lkp_valid, lkp_ready;
  logic [6:0]  ins_data, lkp_data, cam_content;
  logic        res_valid, res_kind, res_hit, res_evict, cam_we;
  logic [3:0]  res_index;
  logic [15:0] cam_match;
  logic [4:0]  fill;

  int n_checks = 0;
  int n_pass   = 0;
  int fill_m   = 0;

  always #5 clk = ~clk;

  cam_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .lkp_valid   (lkp_valid),
    .lkp_ready   (lkp_ready),
    .lkp_data    (lkp_data),
    .res_valid   (res_valid),
    .res_kind    (res_kind),
    .res_hit     (res_hit),
    .res_index   (res_index),
    .res_evict   (res_evict),
    .cam_we      (cam_we),
    .cam_content (cam_content),
    .cam_match   (cam_match),
    .fill        (fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ins_valid = 1'b0;
    lkp_valid = 1'b0;
    cam_match = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    fill_m = 0;
    #1;
  endtask

  // One request from a single requester, checked cycle by cycle against the
  // expected outcome derived from the match vector and the model occupancy.
  task automatic run_op(input bit is_ins, input logic [6:0] d, input logic [15:0] m);
    bit   hit, miss_ins, evict;
    int   idx;
    logic [15:0] low;
    hit      = (m != 16'd0);
    low      = m & (~m + 16'd1);
    idx      = hit ? $clog2(low) : 0;
    miss_ins = is_ins && !hit;
    evict    = miss_ins && (fill_m == 16);
    cam_match = m;
    if (is_ins) begin ins_valid = 1'b1; ins_data = d; end
    else        begin lkp_valid = 1'b1; lkp_data = d; end
    #1;
    chk("grant_ready", 32'(is_ins ? ins_ready : lkp_ready), 32'd1);
    chk("other_ready", 32'(is_ins ? lkp_ready : ins_ready), 32'd0);
    step();
    ins_valid = 1'b0;
    lkp_valid = 1'b0;
    ins_data  = 7'($urandom);
    lkp_data  = 7'($urandom);
    #1;
    chk("probe_content", 32'(cam_content), 32'(d));
    chk("probe_we", 32'(cam_we), 32'd0);
    chk("probe_res_valid", 32'(res_valid), 32'd0);
    step();
    chk("eval_we", 32'(cam_we), 32'd0);
    chk("eval_res_valid", 32'(res_valid), 32'd0);
    chk("eval_content", 32'(cam_content), 32'(d));
    step();
    if (miss_ins) begin
      chk("write_we", 32'(cam_we), 32'd1);
      chk("write_content", 32'(cam_content), 32'(d));
      chk("write_res_valid", 32'(res_valid), 32'd0);
      step();
      if (fill_m < 16) fill_m++;
    end
    chk("resp_valid", 32'(res_valid), 32'd1);
    chk("resp_kind", 32'(res_kind), 32'(is_ins));
    chk("resp_hit", 32'(res_hit), 32'(hit));
    chk("resp_index", 32'(res_index), 32'(idx));
    chk("resp_evict", 32'(res_evict), 32'(evict));
    chk("resp_we", 32'(cam_we), 32'd0);
    step();
    chk("post_res_valid", 32'(res_valid), 32'd0);
    chk("post_res_fields", 32'({res_kind, res_hit, res_index, res_evict}), 32'd0);
    chk("post_fill", 32'(fill), 32'(fill_m));
  endtask

  initial begin
    int grants_obs, grants_exp, next_c;
    bit exp_lkp;

    ins_valid = 1'b0; lkp_valid = 1'b0;
    ins_data  = '0;   lkp_data  = '0;
    cam_match = '0;
    rst_n     = 1'b0;

    // Reset state with both requesters pushing.
    ins_valid = 1'b1; lkp_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ins_ready", 32'(ins_ready), 32'd0);
    chk("rst_lkp_ready", 32'(lkp_ready), 32'd0);
    chk("rst_res", 32'({res_valid, res_kind, res_hit, res_index, res_evict}), 32'd0);
    chk("rst_cam", 32'({cam_we, cam_content}), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    do_reset();

    // Directed cases.
    run_op(1'b0, 7'h2A, 16'h0000);
    run_op(1'b1, 7'h15, 16'h0000);
    run_op(1'b1, 7'h15, 16'h0120);
    run_op(1'b0, 7'h01, 16'h8000);
    run_op(1'b0, 7'h02, 16'hFFFF);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] m;
      m = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
      run_op(1'($urandom_range(0, 1)), 7'($urandom), m);
    end

    // Occupancy saturation: 17 missing inserts from empty.
    do_reset();
    for (int i = 0; i < 17; i++) run_op(1'b1, 7'(i), 16'd0);
    chk("fill_saturated", 32'(fill), 32'd16);

    // Round-robin with both requesters held high; grant cycles predicted by model.
    do_reset();
    ins_valid = 1'b1; lkp_valid = 1'b1; cam_match = '0;
    next_c = 0; exp_lkp = 1'b1; grants_obs = 0; grants_exp = 0;
    for (int c = 0; c < 40; c++) begin
      ins_data = 7'($urandom);
      lkp_data = 7'($urandom);
      #1;
      chk("rr_lkp_ready", 32'(lkp_ready), 32'(c == next_c && exp_lkp));
      chk("rr_ins_ready", 32'(ins_ready), 32'(c == next_c && !exp_lkp));
      if (lkp_ready || ins_ready) grants_obs++;
      if (c == next_c) begin
        grants_exp++;
        if (!exp_lkp && fill_m < 16) fill_m++;
        next_c  = c + (exp_lkp ? 4 : 5);
        exp_lkp = !exp_lkp;
      end
      @(negedge clk);
    end
    ins_valid = 1'b0; lkp_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("rr_grant_count", 32'(grants_obs), 32'(grants_exp));
    chk("rr_fill", 32'(fill), 32'(fill_m));

    // Reset asserted while the write is in progress.
    do_reset();
    run_op(1'b1, 7'h11, 16'd0);
    run_op(1'b1, 7'h12, 16'd0);
    ins_valid = 1'b1; ins_data = 7'h33; cam_match = '0;
    #1;
    chk("abort_accept", 32'(ins_ready), 32'd1);
    step();
    ins_valid = 1'b0;
    step();
    step();
    chk("abort_in_write", 32'(cam_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", 32'(cam_we), 32'd0);
    chk("abort_no_res", 32'(res_valid), 32'd0);
    chk("abort_fill", 32'(fill), 32'd0);
    chk("abort_content", 32'(cam_content), 32'd0);
    fill_m = 0;
    step();
    chk("abort_no_res_later", 32'(res_valid), 32'd0);
    lkp_valid = 1'b1;
    #1;
    chk("abort_ready_in_rst", 32'(lkp_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_idle_grant", 32'(lkp_ready), 32'd1);
    lkp_valid = 1'b0;
    step();
    chk("abort_no_accept", 32'(cam_content), 32'd0);
    run_op(1'b0, 7'h33, 16'h0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
